// File: rtl/jtframe_joy_serial_pkg.sv
// Shared types and constants for the serial joystick chain reader.
package jtframe_joy_serial_pkg;

    typedef enum logic [2:0] {
        LOAD,
        SETTLE,
        SHIFT_LO,
        SHIFT_HI,
        UPDATE
    } state_e;

    localparam int RIGHT = 0;
    localparam int LEFT  = 1;
    localparam int DOWN  = 2;
    localparam int UP    = 3;
    localparam int FIRE1 = 4;

endpackage

// File: rtl/jtframe_joy_serial_deb.sv
// Frame debouncer: latches a frame once it has repeated DEB+1 times
// in a row, and pulses done_o only when the latched state changes.
module jtframe_joy_serial_deb
    import jtframe_joy_serial_pkg::*;
#(
    parameter int NB  = 12,
    parameter int DEB = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upd_i,
    input  logic [NB-1:0] frame_i,
    output logic [NB-1:0] bus_o,
    output logic          done_o
);

    logic [NB-1:0] prev_q;
    logic [NB-1:0] bus_q;
    logic [3:0]    dcnt_q;
    logic [3:0]    dcnt_d;
    logic          done_q;

    always_comb begin
        dcnt_d = '0;
        if (frame_i == prev_q) begin
            dcnt_d = (dcnt_q == 4'(DEB)) ? dcnt_q : dcnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '1;
            bus_q  <= '1;
            dcnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (upd_i) begin
                prev_q <= frame_i;
                dcnt_q <= dcnt_d;
                if (dcnt_d == 4'(DEB) && frame_i != bus_q) begin
                    bus_q  <= frame_i;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus_o  = bus_q;
    assign done_o = done_q;

endmodule

// File: rtl/jtframe_joy_serial.sv
// Reader for 74HC165-style serial joystick chains (NeptUNO/MC2+).
// Pin outputs are registered from the current state, so they trail it by one clk.
module jtframe_joy_serial
    import jtframe_joy_serial_pkg::*;
#(
    parameter int NJOY   = 2,
    parameter int JOYW   = 6,
    parameter int DIV    = 4,
    parameter int DEB    = 0,
    parameter int ACTLOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 joy_data,
    output logic                 joy_clk,
    output logic                 joy_load,
    output logic [NJOY*JOYW-1:0] joy_bus,
    output logic                 frame_done
);

    localparam int NB = NJOY * JOYW;
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IW = (NB > 2) ? $clog2(NB) : 1;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] ridx;
    logic [NB-1:0] raw_q;
    logic [NB-1:0] frame;
    logic          joy_clk_q;
    logic          joy_load_q;
    logic          last;

    assign last  = (cnt_q == CW'(DIV - 1));
    assign ridx  = IW'(NB - 1) - idx_q;
    assign frame = (ACTLOW != 0) ? raw_q : ~raw_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            idx_q      <= '0;
            raw_q      <= '1;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b1;
        end else begin
            joy_load_q <= (state_q != LOAD);
            joy_clk_q  <= (state_q == SHIFT_HI);
            cnt_q      <= (last || state_q == UPDATE) ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                LOAD: begin
                    if (last) state_q <= SETTLE;
                end
                SETTLE: begin
                    if (last) state_q <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (last) begin
                        raw_q[ridx] <= joy_data;
                        state_q     <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (last) begin
                        if (idx_q == IW'(NB - 1)) begin
                            idx_q   <= '0;
                            state_q <= UPDATE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= SHIFT_LO;
                        end
                    end
                end
                UPDATE: state_q <= LOAD;
                default: state_q <= LOAD;
            endcase
        end
    end

    jtframe_joy_serial_deb #(
        .NB  (NB),
        .DEB (DEB)
    ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .upd_i   (state_q == UPDATE),
        .frame_i (frame),
        .bus_o   (joy_bus),
        .done_o  (frame_done)
    );

    assign joy_clk  = joy_clk_q;
    assign joy_load = joy_load_q;

endmodule
